// File: rtl/i2c_temp_responder.sv
// I2C target emulating an ADT7420-style temperature sensor register map.
// Ports: clk, rst_n (sync, active low), scl_in/sda_in (async pads),
//   sda_oe (1 = pull SDA low), temp_in (raw temperature word),
//   cfg (register 0x03), busy (address-matched transaction in flight),
//   temp_snap (pulse when temp_in is captured into the shadow register).
// Option: define I2C_RSP_GLITCH_FLT_EN for a 3-sample input stability filter.
module i2c_temp_responder #(
    parameter logic [6:0] I2C_ADDR = 7'h4B,
    parameter logic [7:0] ID_VAL   = 8'hCB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_in,
    output logic [7:0]  cfg,
    output logic        busy,
    output logic        temp_snap
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    state_t      state, state_nxt;
    logic        scl_q1, scl_q2, sda_q1, sda_q2;
    logic        scl_s, sda_s, scl_d, sda_d;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  cnt;
    logic [7:0]  sh, sh_in, ptr, rd_byte;
    logic [15:0] shadow;
    logic        bit8, match, rw, ack_addr;
    logic        oe_nxt, snap_nxt;

    // Bus idles high, so synchronizers reset to 1 to avoid false edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {scl_q1, scl_q2, sda_q1, sda_q2} <= '1;
        end else begin
            scl_q1 <= scl_in;
            scl_q2 <= scl_q1;
            sda_q1 <= sda_in;
            sda_q2 <= sda_q1;
        end
    end

`ifdef I2C_RSP_GLITCH_FLT_EN
    logic scl_h1, scl_h2, scl_hold;
    logic sda_h1, sda_h2, sda_hold;

    // Output follows the input only once three samples agree;
    // otherwise it holds the last accepted value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {scl_h1, scl_h2, scl_hold} <= '1;
            {sda_h1, sda_h2, sda_hold} <= '1;
        end else begin
            scl_h1   <= scl_q2;
            scl_h2   <= scl_h1;
            scl_hold <= scl_s;
            sda_h1   <= sda_q2;
            sda_h2   <= sda_h1;
            sda_hold <= sda_s;
        end
    end

    assign scl_s = (scl_q2 == scl_h1 && scl_h1 == scl_h2)
                 ? scl_q2 : scl_hold;
    assign sda_s = (sda_q2 == sda_h1 && sda_h1 == sda_h2)
                 ? sda_q2 : sda_hold;
`else
    assign scl_s = scl_q2;
    assign sda_s = sda_q2;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    assign sh_in    = {sh[6:0], sda_s};
    assign bit8     = (cnt == 4'd8);
    assign match    = (sh[7:1] == I2C_ADDR);
    assign rw       = sh[0];
    assign ack_addr = (state == ADDR) && scl_fall && bit8 && match;

    always_comb begin
        case (ptr)
            8'h00:   rd_byte = shadow[15:8];
            8'h01:   rd_byte = shadow[7:0];
            8'h03:   rd_byte = cfg;
            8'h0B:   rd_byte = ID_VAL;
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else if (scl_fall) begin
            unique case (state)
                IDLE:      state_nxt = IDLE;
                ADDR:      if (bit8) state_nxt = match ? ADDR_ACK : IDLE;
                ADDR_ACK:  state_nxt = rw ? RDATA : PTR;
                PTR:       if (bit8) state_nxt = PTR_ACK;
                PTR_ACK:   state_nxt = WDATA;
                WDATA:     if (bit8) state_nxt = WDATA_ACK;
                WDATA_ACK: state_nxt = WDATA;
                RDATA:     if (bit8) state_nxt = RACK;
                RACK:      state_nxt = sh[0] ? IDLE : RDATA;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; SDA only moves on SCL falls.
    always_comb begin
        oe_nxt   = sda_oe;
        snap_nxt = 1'b0;
        if (start_det || stop_det) begin
            oe_nxt = 1'b0;
        end else if (scl_fall) begin
            unique case (state)
                ADDR: begin
                    oe_nxt   = bit8 && match;
                    snap_nxt = ack_addr && rw;
                end
                ADDR_ACK:  oe_nxt = rw ? ~rd_byte[7] : 1'b0;
                PTR:       if (bit8) oe_nxt = 1'b1;
                WDATA:     if (bit8) oe_nxt = 1'b1;
                PTR_ACK:   oe_nxt = 1'b0;
                WDATA_ACK: oe_nxt = 1'b0;
                RDATA:     oe_nxt = bit8 ? 1'b0 : ~sh[6];
                RACK:      oe_nxt = sh[0] ? 1'b0 : ~rd_byte[7];
                default:   oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            sh        <= '0;
            ptr       <= '0;
            cfg       <= '0;
            shadow    <= '0;
            sda_oe    <= 1'b0;
            temp_snap <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sda_oe    <= oe_nxt;
            temp_snap <= snap_nxt;
            if (state_nxt == IDLE) busy <= 1'b0;
            else if (ack_addr)     busy <= 1'b1;
            if (start_det || stop_det) begin
                cnt <= '0;
            end else if (scl_rise) begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (!bit8) cnt <= cnt + 4'd1;
                        sh <= sh_in;
                    end
                    RDATA: if (!bit8) cnt <= cnt + 4'd1;
                    RACK:  sh <= sh_in;
                    default: ;
                endcase
                if (state == PTR && cnt == 4'd7) ptr <= sh_in;
                if (state == WDATA && cnt == 4'd7) begin
                    if (ptr == 8'h03) cfg <= sh_in;
                    ptr <= ptr + 8'd1;
                end
            end else if (scl_fall) begin
                case (state)
                    ADDR: if (ack_addr && rw) shadow <= temp_in;
                    ADDR_ACK: begin
                        cnt <= '0;
                        if (rw) sh <= rd_byte;
                    end
                    PTR_ACK, WDATA_ACK: cnt <= '0;
                    RDATA: begin
                        if (bit8) ptr <= ptr + 8'd1;
                        else      sh  <= {sh[6:0], 1'b0};
                    end
                    RACK: begin
                        cnt <= '0;
                        if (!sh[0]) sh <= rd_byte;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Directed bench for i2c_temp_responder acting as an I2C initiator.
// Drives SCL/SDA pads, models the open-drain line, checks bytes and flags.
module tb_i2c_temp_responder;

    localparam int Q = 10;

`ifdef I2C_RSP_GLITCH_FLT_EN
    localparam logic GLITCH_EXP = 1'b0;
`else
    localparam logic GLITCH_EXP = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda = 1'b1;
    logic [15:0] temp_in = 16'h0000;
    logic        sda_oe, busy, temp_snap;
    logic [7:0]  cfg;
    logic        sda_line;

    assign sda_line = sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_temp_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .temp_in   (temp_in),
        .cfg       (cfg),
        .busy      (busy),
        .temp_snap (temp_snap)
    );

    int n_chk = 0;
    int n_pass = 0;
    int snap_cnt = 0;
    bit saw_oe = 0;
    bit saw_busy = 0;
    bit saw_start = 0;

    always @(negedge clk) begin
        if (temp_snap)     snap_cnt++;
        if (sda_oe)        saw_oe = 1;
        if (busy)          saw_busy = 1;
        if (dut.start_det) saw_start = 1;
    end

    initial begin
        #800us;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h exp %h", tag, got, exp);
    endtask

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic xfer(input logic v, output logic r);
        sda = v;
        qw();
        scl = 1'b1;
        qw();
        r = sda_line;
        qw();
        scl = 1'b0;
        qw();
    endtask

    task automatic i2c_start();
        sda = 1'b0;
        qw();
        scl = 1'b0;
        qw();
    endtask

    task automatic i2c_rstart();
        sda = 1'b1;
        qw();
        scl = 1'b1;
        qw();
        sda = 1'b0;
        qw();
        scl = 1'b0;
        qw();
    endtask

    task automatic i2c_stop();
        sda = 1'b0;
        qw();
        scl = 1'b1;
        qw();
        sda = 1'b1;
        qw();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) xfer(b[i], r);
        xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            xfer(1'b1, r);
            b[i] = r;
        end
        xfer(nack, r);
    endtask

    initial begin
        logic       ack, r;
        logic [7:0] d;

        repeat (5) @(negedge clk);
        chk("rst_oe", 16'(sda_oe), 16'h0);
        chk("rst_cfg", 16'(cfg), 16'h00);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_snap", 16'(temp_snap), 16'h0);
        rst_n = 1'b1;
        qw();

        // ID register read through repeated START
        i2c_start();
        wr_byte(8'h96, ack);
        chk("id_ack_w", 16'(ack), 16'h1);
        wr_byte(8'h0B, ack);
        chk("id_ack_ptr", 16'(ack), 16'h1);
        i2c_rstart();
        wr_byte(8'h97, ack);
        chk("id_ack_r", 16'(ack), 16'h1);
        chk("id_busy", 16'(busy), 16'h1);
        rd_byte(1'b1, d);
        chk("id_data", 16'(d), 16'h00CB);
        i2c_stop();
        chk("id_oe_end", 16'(sda_oe), 16'h0);
        chk("id_busy_end", 16'(busy), 16'h0);

        // Temperature read; temp_in changes between bytes
        temp_in = 16'h0C80;
        i2c_start();
        wr_byte(8'h96, ack);
        wr_byte(8'h00, ack);
        i2c_rstart();
        snap_cnt = 0;
        wr_byte(8'h97, ack);
        rd_byte(1'b0, d);
        chk("tmp_msb", 16'(d), 16'h000C);
        temp_in = 16'h1234;
        rd_byte(1'b1, d);
        chk("tmp_lsb", 16'(d), 16'h0080);
        i2c_stop();
        chk("tmp_snap_cnt", 16'(snap_cnt), 16'd1);

        // Config write with auto-increment
        i2c_start();
        wr_byte(8'h96, ack);
        wr_byte(8'h03, ack);
        wr_byte(8'hA5, ack);
        chk("cfg_ack", 16'(ack), 16'h1);
        wr_byte(8'h5A, ack);
        i2c_stop();
        chk("cfg_val", 16'(cfg), 16'h00A5);
        chk("cfg_ptr", 16'(dut.ptr), 16'h0005);
        i2c_start();
        wr_byte(8'h96, ack);
        wr_byte(8'h03, ack);
        i2c_rstart();
        wr_byte(8'h97, ack);
        rd_byte(1'b1, d);
        i2c_stop();
        chk("cfg_rd", 16'(d), 16'h00A5);

        // Pointer wrap 0xFF -> 0x00, then read from 0x00 with new snapshot
        i2c_start();
        wr_byte(8'h96, ack);
        wr_byte(8'hFF, ack);
        wr_byte(8'h11, ack);
        i2c_stop();
        chk("wrap_ptr", 16'(dut.ptr), 16'h0000);
        chk("wrap_cfg", 16'(cfg), 16'h00A5);
        i2c_start();
        wr_byte(8'h97, ack);
        rd_byte(1'b0, d);
        chk("wrap_msb", 16'(d), 16'h0012);
        rd_byte(1'b1, d);
        chk("wrap_lsb", 16'(d), 16'h0034);
        i2c_stop();

        // Address mismatch
        saw_oe = 0;
        saw_busy = 0;
        i2c_start();
        wr_byte(8'h90, ack);
        chk("mis_ack", 16'(ack), 16'h0);
        wr_byte(8'h00, ack);
        chk("mis_ack2", 16'(ack), 16'h0);
        i2c_stop();
        chk("mis_oe", 16'(saw_oe), 16'h0);
        chk("mis_busy", 16'(saw_busy), 16'h0);

        // STOP after 4 data bits of a write to 0x03
        i2c_start();
        wr_byte(8'h96, ack);
        wr_byte(8'h03, ack);
        for (int i = 0; i < 4; i++) xfer(1'b0, r);
        i2c_stop();
        chk("mid_cfg", 16'(cfg), 16'h00A5);
        chk("mid_state", 16'(dut.state), 16'h0);
        chk("mid_oe", 16'(sda_oe), 16'h0);

        // Reset while driving a 0 bit of the ID byte
        i2c_start();
        wr_byte(8'h96, ack);
        wr_byte(8'h0B, ack);
        i2c_rstart();
        wr_byte(8'h97, ack);
        xfer(1'b1, r);
        xfer(1'b1, r);
        chk("rr_oe_on", 16'(sda_oe), 16'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rr_oe_off", 16'(sda_oe), 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        qw();
        i2c_stop();
        chk("rr_cfg", 16'(cfg), 16'h00);
        chk("rr_busy", 16'(busy), 16'h0);

        // 2-cycle SDA low glitch with SCL high
        saw_start = 0;
        saw_busy = 0;
        @(negedge clk);
        sda = 1'b0;
        repeat (2) @(negedge clk);
        sda = 1'b1;
        qw();
        chk("glitch_start", 16'(saw_start), 16'(GLITCH_EXP));
        chk("glitch_busy", 16'(saw_busy), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_temp_responder.md
# i2c_temp_responder

Synthesizable I2C target that emulates the board temperature sensor (ADT7420-style register map) on the same SCL/SDA pins the temperature-sensor initiator drives. Used as a loopback partner for the temperature display path in simulation and on hardware: it answers address/pointer/read/write transactions and returns a caller-supplied temperature word. All logic runs on the system clock, with SCL/SDA oversampled.

## Interface

- `I2C_ADDR`, default `7'h4B`: 7-bit target address matched after START.
- `ID_VAL`, default `8'hCB`: value returned from register 0x0B.
- `clk`  input  1  system clock, 100 MHz.
- `rst_n`  input  1  synchronous, active-low reset.
- `scl_in`  input  1  SCL pad value (asynchronous).
- `sda_in`  input  1  SDA pad value (asynchronous).
- `sda_oe`  output  1  1 = pull SDA low; 0 = release. The top level builds the open-drain pad.
- `temp_in`  input  16  raw temperature register value, left-justified 13-bit format.
- `cfg`  output  8  configuration register 0x03.
- `busy`  output  1  high from an address-matched START until STOP or a return to IDLE.
- `temp_snap`  output  1  one-cycle pulse when `temp_in` is captured into the shadow register.

## Operation

- **Input synchronisation:** SCL and SDA each pass through a 2-flop synchronizer.
- **Edge detection:** edges are detected on the synchronized values.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit transfer:**
  - Received bits are sampled on a detected SCL rise, MSB first.
  - `sda_oe` changes only on a detected SCL fall.
- **FSM states:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
  - IDLE -> ADDR on START.
  - ADDR: after 8 bits, on a match -> ADDR_ACK; on a mismatch -> IDLE with `sda_oe` held 0 until the next START.
  - ADDR_ACK with R/W=0 -> PTR. With R/W=1: `temp_in` is copied to the shadow register, `temp_snap` pulses, then -> RDATA.
  - PTR: 8 bits go to the pointer -> PTR_ACK -> WDATA.
  - WDATA: after 8 bits, a write to register 0x03 updates `cfg`; writes to any other address are ACKed and discarded. The pointer increments -> WDATA_ACK -> WDATA.
  - RDATA: shifts out the register at the pointer.
    - 0x00 = shadow[15:8]; 0x01 = shadow[7:0].
    - 0x02 = 8'h00; 0x03 = `cfg`.
    - 0x0B = `ID_VAL`; all other addresses = 8'h00.
    - After 8 bits, the pointer increments -> RACK.
  - RACK: initiator ACK (SDA=0) -> RDATA with the next byte. NACK -> IDLE.
- **ACK drive:** the target asserts `sda_oe` on the SCL fall ending bit 8 and releases it on the next SCL fall.
- **Read data drive:** `sda_oe` = ~bit. The first bit is driven on the SCL fall that ends the ACK clock.
- **Pointer:** 8 bits, increments modulo 256 (0xFF -> 0x00). It is retained across transactions; reset value 0x00.
- **Repeated START (any state):** -> ADDR; `sda_oe` released; pointer kept.
- **STOP (any state, including mid-byte):** -> IDLE; `sda_oe` = 0; a partial byte is discarded.
- **START and STOP:** cannot coincide. A START seen in the same cycle as a bit-sample SCL rise takes priority.

## Timing

- Reset values: `sda_oe`=0, `cfg`=8'h00, `busy`=0, `temp_snap`=0; FSM = IDLE, pointer = 0, shadow = 0.
- Reset is synchronous and takes effect at the next `clk` edge. Asserting it mid-transaction releases SDA on that edge.
- Latency: pad SCL fall -> `sda_oe` update is 3 `clk` cycles (2 synchronizer + 1 register).
- Pad SCL rise -> bit sampled is 3 `clk` cycles.
- `temp_snap` is asserted for exactly 1 cycle, in the cycle the shadow register loads. This is the same cycle `sda_oe` rises for the address ACK.
- `cfg` updates 1 cycle after the synchronized SCL rise that samples bit 0 of a data byte written to 0x03.
- Minimum supported SCL high/low time is 8 `clk` cycles (10 with the filter enabled). 100/400 kHz SCL is well inside this.

## Configuration

- `I2C_RSP_GLITCH_FLT_EN` defined: each synchronized input passes through a 3-sample stability filter.
  - The output changes only after 3 consecutive equal samples.
  - Pulses of 2 cycles or less are rejected.
  - All latencies above grow by 2 cycles.
- Not defined: no filter; the synchronizer output feeds edge detection directly.

## Test plan

- **ID read:** write 0x96 + pointer 0x0B, repeated START, read 0x97 one byte with NACK -> byte 0xCB; ACKs on both address bytes and the pointer; `sda_oe`=0 after STOP.
- **Temperature read:** `temp_in`=16'h0C80, pointer 0x00, read 2 bytes (ACK then NACK) -> 0x0C, 0x80. `temp_snap` pulses once. Changing `temp_in` to 16'h1234 mid-read must not alter byte 2.
- **Config write with auto-increment:** pointer 0x03, data 0xA5, 0x5A -> `cfg`=0xA5, pointer ends at 0x05. A subsequent read from 0x03 returns 0xA5.
- **Address mismatch:** write address 0x48 (0x90) -> no ACK, `sda_oe` stays 0 and `busy` stays 0 for the whole transaction.
- **STOP mid-byte:** STOP after 4 data bits during a write to 0x03 -> `cfg` unchanged, FSM in IDLE, `sda_oe`=0. Reset asserted mid-read -> `sda_oe`=0 on the next edge.
- **Filter build only:** a 2-cycle SDA low glitch while SCL is high -> no START detected, `busy` stays 0. In a non-filter build the same stimulus produces a START.
